serial_config_shifter: RTL and testbench

- Downstream consumer of the serial-clock divider: uses its divided clock and its four phase strobes to shift a multi-byte configuration word onto a two-wire, open-drain serial bus.
- Frame format: START, then NUM_BYTES bytes sent MSB first, each followed by an acknowledge slot, then STOP.
- Drives the divider's clock enable, so the serial clock runs only during a transfer.
- Reports busy, a one-cycle done pulse and a sticky NACK flag to the configuration sequencer upstream.

---
 rtl/serial_config_shifter_if.sv | 49 ++++
 rtl/serial_config_shifter.sv | 205 ++++++++++++++++++++
 tb/tb_serial_config_shifter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_config_shifter_if.sv
// ---------------------------------------------------------------------------
// serial_config_shifter_if
//   Bundles every signal that serial_config_shifter shares with the outside
//   world, apart from clk and reset.
//   Names carry the i_/o_ prefix as seen from the shifter.
//
//   Sequencer side : i_start, i_dataIn, o_busy, o_done, o_ackError
//   Divider side   : i_serialClk, i_clkRisingEdge, i_clkFallingEdge,
//                    i_clkMiddleOfHigh, i_clkMiddleOfLow, o_enableClk
//   Serial bus     : i_serialDataIn, o_serialClkOut, o_serialDataOut,
//                    o_serialDataOe
//
//   Modports:
//     slave  - the shifter itself
//     master - whatever drives it (sequencer + divider + bus model)
// ---------------------------------------------------------------------------
interface serial_config_shifter_if #(
  parameter int DATA_W = 24
);
  logic              i_start;
  logic [DATA_W-1:0] i_dataIn;
  logic              i_serialClk;
  logic              i_clkRisingEdge;
  logic              i_clkFallingEdge;
  logic              i_clkMiddleOfHigh;
  logic              i_clkMiddleOfLow;
  logic              i_serialDataIn;
  logic              o_enableClk;
  logic              o_serialClkOut;
  logic              o_serialDataOut;
  logic              o_serialDataOe;
  logic              o_busy;
  logic              o_done;
  logic              o_ackError;

  modport slave (
    input  i_start, i_dataIn, i_serialClk, i_clkRisingEdge, i_clkFallingEdge,
           i_clkMiddleOfHigh, i_clkMiddleOfLow, i_serialDataIn,
    output o_enableClk, o_serialClkOut, o_serialDataOut, o_serialDataOe,
           o_busy, o_done, o_ackError
  );

  modport master (
    output i_start, i_dataIn, i_serialClk, i_clkRisingEdge, i_clkFallingEdge,
           i_clkMiddleOfHigh, i_clkMiddleOfLow, i_serialDataIn,
    input  o_enableClk, o_serialClkOut, o_serialDataOut, o_serialDataOe,
           o_busy, o_done, o_ackError
  );
endinterface

// File: rtl/serial_config_shifter.sv
// ---------------------------------------------------------------------------
// serial_config_shifter
//   Shifts a NUM_BYTES-byte configuration word onto a two-wire open-drain
//   serial bus.  The frame is START, then each byte MSB first followed by an
//   acknowledge slot, then STOP.  The serial clock comes from an external
//   divider whose enable is driven from here, so the bus clock only runs
//   while a frame is in flight.  All outputs are registered.
//
//   Ports:
//     clk    - system clock (the divider runs on the same clock)
//     reset  - asynchronous, active-low reset
//     bus    - serial_config_shifter_if.slave (sequencer, divider, bus lines)
//
//   Parameters:
//     NUM_BYTES - bytes per frame, 1..4; the payload width is 8*NUM_BYTES
//
//   Build option:
//     SERIAL_ABORT_ON_NACK_EN - when defined, a NACK ends the frame at once
//     (straight to STOP); otherwise the NACK is only recorded in ack_error
//     and every byte is still sent.
// ---------------------------------------------------------------------------
module serial_config_shifter #(
  parameter int NUM_BYTES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  serial_config_shifter_if.slave  bus
);
  localparam int DATA_W     = 8 * NUM_BYTES;
  localparam int BYTE_CNT_W = 2;

  typedef enum logic [2:0] {IDLE, START, BITS, ACK, STOP_LOW, STOP, DONE} stateT;

  stateT                 r_state;
  logic [DATA_W-1:0]     r_shift;
  logic [2:0]            r_bitCnt;
  logic [BYTE_CNT_W-1:0] r_byteCnt;
  logic                  r_ackPending;
  logic                  r_enableClk;
  logic                  r_serialClkOut;
  logic                  r_serialDataOut;
  logic                  r_serialDataOe;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ackError;

  stateT                 w_nextState;
  logic [DATA_W-1:0]     w_shiftNext;
  logic [2:0]            w_bitCntNext;
  logic [BYTE_CNT_W-1:0] w_byteCntNext;
  logic                  w_ackPendingNext;
  logic                  w_enableClkNext;
  logic                  w_serialClkOutNext;
  logic                  w_serialDataOutNext;
  logic                  w_serialDataOeNext;
  logic                  w_busyNext;
  logic                  w_doneNext;
  logic                  w_ackErrorNext;
  logic                  w_abortNow;
  logic                  w_unusedStrobes;

  // The edge strobes are part of the divider's interface but sequencing is
  // done purely on the middle-of-phase strobes, where the bus is stable.
  assign w_unusedStrobes = bus.i_clkRisingEdge ^ bus.i_clkFallingEdge;

  // A NACK only cuts the frame short when the abort option is built in.
`ifdef SERIAL_ABORT_ON_NACK_EN
  assign w_abortNow = bus.i_serialDataIn;
`else
  assign w_abortNow = 1'b0;
`endif

  // State register: holds the FSM state together with every registered
  // output and datapath register, so all outputs come straight from flops.
  // Reset releases the bus high and drops the divider enable immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_shift         <= '0;
      r_bitCnt        <= '0;
      r_byteCnt       <= '0;
      r_ackPending    <= 1'b0;
      r_enableClk     <= 1'b0;
      r_serialClkOut  <= 1'b1;
      r_serialDataOut <= 1'b1;
      r_serialDataOe  <= 1'b1;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_ackError      <= 1'b0;
    end else begin
      r_state         <= w_nextState;
      r_shift         <= w_shiftNext;
      r_bitCnt        <= w_bitCntNext;
      r_byteCnt       <= w_byteCntNext;
      r_ackPending    <= w_ackPendingNext;
      r_enableClk     <= w_enableClkNext;
      r_serialClkOut  <= w_serialClkOutNext;
      r_serialDataOut <= w_serialDataOutNext;
      r_serialDataOe  <= w_serialDataOeNext;
      r_busy          <= w_busyNext;
      r_done          <= w_doneNext;
      r_ackError      <= w_ackErrorNext;
    end
  end

  // Next-state logic: START/ACK/STOP act in the middle of the high phase
  // (bus conditions and sampling), data and release act in the middle of
  // the low phase so the data line only moves while the clock is low.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:     if (bus.i_start)                         w_nextState = START;
      START:    if (bus.i_clkMiddleOfHigh)               w_nextState = BITS;
      BITS:     if (bus.i_clkMiddleOfLow && r_ackPending) w_nextState = ACK;
      ACK: begin
        if (bus.i_clkMiddleOfHigh) begin
          if (w_abortNow)              w_nextState = STOP_LOW;
          else if (r_byteCnt != '0)    w_nextState = BITS;
          else                         w_nextState = STOP_LOW;
        end
      end
      STOP_LOW: if (bus.i_clkMiddleOfLow)                w_nextState = STOP;
      STOP:     if (bus.i_clkMiddleOfHigh)               w_nextState = DONE;
      DONE:                                              w_nextState = IDLE;
      default:                                           w_nextState = IDLE;
    endcase
  end

  // Output logic: computes the next value of each registered output and of
  // the shift/counter datapath.  The edge that releases the line for the
  // acknowledge slot does not shift, so exactly eight bits leave per byte.
  // busy drops on the STOP edge so it is already low while done pulses.
  always_comb begin
    w_shiftNext         = r_shift;
    w_bitCntNext        = r_bitCnt;
    w_byteCntNext       = r_byteCnt;
    w_ackPendingNext    = r_ackPending;
    w_serialDataOutNext = r_serialDataOut;
    w_serialDataOeNext  = r_serialDataOe;
    w_busyNext          = r_busy;
    w_ackErrorNext      = r_ackError;
    case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_shiftNext      = bus.i_dataIn;
          w_bitCntNext     = 3'd7;
          w_byteCntNext    = BYTE_CNT_W'(NUM_BYTES - 1);
          w_ackPendingNext = 1'b0;
          w_ackErrorNext   = 1'b0;
          w_busyNext       = 1'b1;
        end
      end
      START: begin
        if (bus.i_clkMiddleOfHigh) w_serialDataOutNext = 1'b0;
      end
      BITS: begin
        if (bus.i_clkMiddleOfLow) begin
          if (r_ackPending) begin
            w_serialDataOeNext = 1'b0;
            w_ackPendingNext   = 1'b0;
          end else begin
            w_serialDataOeNext  = 1'b1;
            w_serialDataOutNext = r_shift[DATA_W-1];
            w_shiftNext         = {r_shift[DATA_W-2:0], 1'b0};
            if (r_bitCnt == 3'd0) w_ackPendingNext = 1'b1;
            else                  w_bitCntNext     = r_bitCnt - 3'd1;
          end
        end
      end
      ACK: begin
        if (bus.i_clkMiddleOfHigh) begin
          if (bus.i_serialDataIn) w_ackErrorNext = 1'b1;
          if (!w_abortNow && (r_byteCnt != '0)) begin
            w_byteCntNext = r_byteCnt - 1'b1;
            w_bitCntNext  = 3'd7;
          end
        end
      end
      STOP_LOW: begin
        if (bus.i_clkMiddleOfLow) begin
          w_serialDataOeNext  = 1'b1;
          w_serialDataOutNext = 1'b0;
        end
      end
      STOP: begin
        if (bus.i_clkMiddleOfHigh) begin
          w_serialDataOutNext = 1'b1;
          w_busyNext          = 1'b0;
        end
      end
      default: ;
    endcase
    w_doneNext         = (w_nextState == DONE);
    w_enableClkNext    = !((w_nextState == IDLE) || (w_nextState == DONE));
    w_serialClkOutNext = (w_nextState == IDLE) ? 1'b1 : bus.i_serialClk;
  end

  assign bus.o_enableClk     = r_enableClk;
  assign bus.o_serialClkOut  = r_serialClkOut;
  assign bus.o_serialDataOut = r_serialDataOut;
  assign bus.o_serialDataOe  = r_serialDataOe;
  assign bus.o_busy          = r_busy;
  assign bus.o_done          = r_done;
  assign bus.o_ackError      = r_ackError;
endmodule

// File: tb/tb_serial_config_shifter.sv
// ---------------------------------------------------------------------------
// tb_serial_config_shifter
//   Directed bench for serial_config_shifter with a small divider model
//   (8 system clocks per serial clock) and a bus model that answers each
//   acknowledge slot from nackMask.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_config_shifter;
  localparam int NUM_BYTES = 3;
  localparam int DATA_W    = 8 * NUM_BYTES;
  localparam int MAX_RISE  = 512;

  logic clk;
  logic resetN;
  int   passCount = 0;
  int   checkCount = 0;

  serial_config_shifter_if #(.DATA_W(DATA_W)) bus ();

  serial_config_shifter #(.NUM_BYTES(NUM_BYTES)) dut (
    .clk   (clk),
    .reset (resetN),
    .bus   (bus.slave)
  );

  // System clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: counter runs only while enabled; high for counts 0..3,
  // low for 4..7, strobes in the middle of each half.
  logic [2:0] divCnt;
  always @(posedge clk or negedge resetN) begin
    if (!resetN)              divCnt <= 3'd0;
    else if (bus.o_enableClk) divCnt <= divCnt + 3'd1;
    else                      divCnt <= 3'd0;
  end
  assign bus.i_serialClk       = ~divCnt[2];
  assign bus.i_clkRisingEdge   = bus.o_enableClk && (divCnt == 3'd0);
  assign bus.i_clkMiddleOfHigh = bus.o_enableClk && (divCnt == 3'd2);
  assign bus.i_clkFallingEdge  = bus.o_enableClk && (divCnt == 3'd4);
  assign bus.i_clkMiddleOfLow  = bus.o_enableClk && (divCnt == 3'd6);

  // Bus model: a driven line reads back its own value; a released line is
  // answered by the slave, bit ackIdx of nackMask (1 = NACK).
  logic [3:0] nackMask = 4'b0000;
  logic [1:0] ackIdx = 2'd0;
  assign bus.i_serialDataIn = bus.o_serialDataOe ? bus.o_serialDataOut : nackMask[ackIdx];

  // Bus monitor, sampled on the falling system clock edge.
  int   riseCnt = 0;
  int   doneCnt = 0;
  int   highFalls = 0;
  int   highRises = 0;
  logic riseData [0:MAX_RISE-1];
  logic riseOe   [0:MAX_RISE-1];
  logic prevClk = 1'b1;
  logic prevData = 1'b1;
  logic prevBusy = 1'b0;
  always @(negedge clk) begin
    if (resetN) begin
      if (bus.o_serialClkOut && !prevClk) begin
        if (riseCnt < MAX_RISE) begin
          riseData[riseCnt] = bus.o_serialDataOut;
          riseOe[riseCnt]   = bus.o_serialDataOe;
        end
        riseCnt++;
      end
      if (!bus.o_serialClkOut && prevClk && !bus.o_serialDataOe) ackIdx = ackIdx + 2'd1;
      if (bus.o_busy && !prevBusy) ackIdx = 2'd0;
      if ((bus.o_serialDataOut !== prevData) && (bus.o_serialClkOut || prevClk)) begin
        if (prevData) highFalls++;
        else          highRises++;
      end
      if (bus.o_done) doneCnt++;
    end
    prevClk  = bus.o_serialClkOut;
    prevData = bus.o_serialDataOut;
    prevBusy = bus.o_busy;
  end

  logic [7:0] expBytes [0:2] = '{8'h34, 8'h1E, 8'h05};

  function automatic logic [7:0] capturedByte(input int idx);
    logic [7:0] v = 8'h00;
    for (int b = 0; b < 8; b++) v = {v[6:0], riseData[idx + b]};
    return v;
  endfunction

  task automatic applyStimulus(input logic [DATA_W-1:0] data);
    @(negedge clk);
    bus.i_dataIn = data;
    bus.i_start  = 1'b1;
    @(negedge clk);
    bus.i_start  = 1'b0;
  endtask

  task automatic waitDone(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.o_done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitRises(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (riseCnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reset values, with start asserted during reset.
  task automatic test_reset;
    resetN = 1'b0;
    bus.i_start  = 1'b1;
    bus.i_dataIn = 24'h341E05;
    @(posedge clk); #1;
    checkCount++; if (bus.o_busy !== 1'b0)          $display("[TB] FAIL reset_busy: got %b, expected 0", bus.o_busy); else passCount++;
    checkCount++; if (bus.o_enableClk !== 1'b0)     $display("[TB] FAIL reset_enable: got %b, expected 0", bus.o_enableClk); else passCount++;
    checkCount++; if (bus.o_serialClkOut !== 1'b1)  $display("[TB] FAIL reset_sclk: got %b, expected 1", bus.o_serialClkOut); else passCount++;
    checkCount++; if (bus.o_serialDataOut !== 1'b1) $display("[TB] FAIL reset_sdata: got %b, expected 1", bus.o_serialDataOut); else passCount++;
    checkCount++; if (bus.o_serialDataOe !== 1'b1)  $display("[TB] FAIL reset_oe: got %b, expected 1", bus.o_serialDataOe); else passCount++;
    checkCount++; if (bus.o_done !== 1'b0)          $display("[TB] FAIL reset_done: got %b, expected 0", bus.o_done); else passCount++;
    checkCount++; if (bus.o_ackError !== 1'b0)      $display("[TB] FAIL reset_ackerr: got %b, expected 0", bus.o_ackError); else passCount++;
    @(negedge clk);
    resetN = 1'b1;
    bus.i_start = 1'b0;
    repeat (2) @(negedge clk);
    checkCount++; if (bus.o_busy !== 1'b0) $display("[TB] FAIL reset_start_ignored: got busy %b, expected 0", bus.o_busy); else passCount++;
  endtask

  // Reset asserted in the middle of the first byte.
  task automatic test_reset_mid_frame;
    int base = riseCnt;
    bit ok;
    nackMask = 4'b0000;
    applyStimulus(24'h341E05);
    waitRises(base + 3, ok);
    checkCount++; if (!ok) $display("[TB] FAIL midreset_bits_reached: got %0d rises, expected 3", riseCnt - base); else passCount++;
    #2 resetN = 1'b0;
    #1;
    checkCount++; if (bus.o_serialDataOe !== 1'b1)  $display("[TB] FAIL midreset_oe: got %b, expected 1", bus.o_serialDataOe); else passCount++;
    checkCount++; if (bus.o_serialDataOut !== 1'b1) $display("[TB] FAIL midreset_sdata: got %b, expected 1", bus.o_serialDataOut); else passCount++;
    checkCount++; if (bus.o_serialClkOut !== 1'b1)  $display("[TB] FAIL midreset_sclk: got %b, expected 1", bus.o_serialClkOut); else passCount++;
    checkCount++; if (bus.o_busy !== 1'b0)          $display("[TB] FAIL midreset_busy: got %b, expected 0", bus.o_busy); else passCount++;
    checkCount++; if (bus.o_enableClk !== 1'b0)     $display("[TB] FAIL midreset_enable: got %b, expected 0", bus.o_enableClk); else passCount++;
    @(negedge clk);
    resetN = 1'b1;
    repeat (3) @(negedge clk);
    checkCount++; if (bus.o_busy !== 1'b0 || bus.o_enableClk !== 1'b0)
      $display("[TB] FAIL midreset_idle: got busy %b enable %b, expected 0 0", bus.o_busy, bus.o_enableClk); else passCount++;
  endtask

  // Nominal frame, every byte acknowledged.
  task automatic test_frame;
    int base = riseCnt;
    int doneBase = doneCnt;
    int fallBase = highFalls;
    int riseBase = highRises;
    bit seen;
    nackMask = 4'b0000;
    applyStimulus(24'h341E05);
    waitDone(seen);
    repeat (3) @(negedge clk);
    checkCount++; if (!seen) $display("[TB] FAIL frame_done_seen: got no done, expected done"); else passCount++;
    checkCount++; if (riseCnt - base !== 28) $display("[TB] FAIL frame_clock_count: got %0d, expected 28", riseCnt - base); else passCount++;
    for (int k = 0; k < 3; k++) begin
      checkCount++; if (capturedByte(base + 9*k) !== expBytes[k])
        $display("[TB] FAIL frame_byte%0d: got %02h, expected %02h", k, capturedByte(base + 9*k), expBytes[k]); else passCount++;
      checkCount++; if (riseOe[base + 9*k + 8] !== 1'b0)
        $display("[TB] FAIL frame_ack%0d_released: got oe %b, expected 0", k, riseOe[base + 9*k + 8]); else passCount++;
    end
    checkCount++; if (riseData[base + 27] !== 1'b0 || riseOe[base + 27] !== 1'b1)
      $display("[TB] FAIL frame_stop_low: got data %b oe %b, expected 0 1", riseData[base + 27], riseOe[base + 27]); else passCount++;
    checkCount++; if (highFalls - fallBase !== 1) $display("[TB] FAIL frame_start_cond: got %0d, expected 1", highFalls - fallBase); else passCount++;
    checkCount++; if (highRises - riseBase !== 1) $display("[TB] FAIL frame_stop_cond: got %0d, expected 1", highRises - riseBase); else passCount++;
    checkCount++; if (doneCnt - doneBase !== 1) $display("[TB] FAIL frame_done_pulses: got %0d, expected 1", doneCnt - doneBase); else passCount++;
    checkCount++; if (bus.o_ackError !== 1'b0) $display("[TB] FAIL frame_ackerr: got %b, expected 0", bus.o_ackError); else passCount++;
    checkCount++; if (bus.o_serialDataOut !== 1'b1) $display("[TB] FAIL frame_idle_sdata: got %b, expected 1", bus.o_serialDataOut); else passCount++;
  endtask

  // NACK on the second acknowledge slot.
  task automatic test_nack;
    int base = riseCnt;
    int nBytes;
    bit seen;
`ifdef SERIAL_ABORT_ON_NACK_EN
    nBytes = 2;
`else
    nBytes = 3;
`endif
    nackMask = 4'b0010;
    applyStimulus(24'h341E05);
    waitDone(seen);
    repeat (3) @(negedge clk);
    checkCount++; if (!seen) $display("[TB] FAIL nack_done_seen: got no done, expected done"); else passCount++;
    checkCount++; if (riseCnt - base !== 9*nBytes + 1)
      $display("[TB] FAIL nack_clock_count: got %0d, expected %0d", riseCnt - base, 9*nBytes + 1); else passCount++;
    for (int k = 0; k < nBytes; k++) begin
      checkCount++; if (capturedByte(base + 9*k) !== expBytes[k])
        $display("[TB] FAIL nack_byte%0d: got %02h, expected %02h", k, capturedByte(base + 9*k), expBytes[k]); else passCount++;
    end
    checkCount++; if (riseData[base + 9*nBytes] !== 1'b0 || riseOe[base + 9*nBytes] !== 1'b1)
      $display("[TB] FAIL nack_stop_low: got data %b oe %b, expected 0 1", riseData[base + 9*nBytes], riseOe[base + 9*nBytes]); else passCount++;
    checkCount++; if (bus.o_ackError !== 1'b1) $display("[TB] FAIL nack_ackerr: got %b, expected 1", bus.o_ackError); else passCount++;
    repeat (5) @(negedge clk);
    checkCount++; if (bus.o_ackError !== 1'b1) $display("[TB] FAIL nack_ackerr_sticky: got %b, expected 1", bus.o_ackError); else passCount++;
  endtask

  // A second start during the first byte must neither restart nor queue.
  task automatic test_back_to_back;
    int base = riseCnt;
    int doneBase = doneCnt;
    bit ok;
    bit seen;
    nackMask = 4'b0000;
    applyStimulus(24'h341E05);
    waitRises(base + 3, ok);
    checkCount++; if (!ok) $display("[TB] FAIL b2b_bits_reached: got %0d rises, expected 3", riseCnt - base); else passCount++;
    applyStimulus(24'hFFFFFF);
    waitDone(seen);
    repeat (40) @(negedge clk);
    checkCount++; if (!seen) $display("[TB] FAIL b2b_done_seen: got no done, expected done"); else passCount++;
    checkCount++; if (riseCnt - base !== 28) $display("[TB] FAIL b2b_clock_count: got %0d, expected 28", riseCnt - base); else passCount++;
    for (int k = 0; k < 3; k++) begin
      checkCount++; if (capturedByte(base + 9*k) !== expBytes[k])
        $display("[TB] FAIL b2b_byte%0d: got %02h, expected %02h", k, capturedByte(base + 9*k), expBytes[k]); else passCount++;
    end
    checkCount++; if (doneCnt - doneBase !== 1) $display("[TB] FAIL b2b_done_pulses: got %0d, expected 1", doneCnt - doneBase); else passCount++;
    checkCount++; if (bus.o_busy !== 1'b0) $display("[TB] FAIL b2b_not_queued: got busy %b, expected 0", bus.o_busy); else passCount++;
  endtask

  // start in the DONE cycle is ignored; one cycle later it is accepted.
  task automatic test_done_cycle;
    bit seen = 1'b0;
    bit seen2;
    nackMask = 4'b0010;
    applyStimulus(24'h341E05);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.o_done) begin
        seen = 1'b1;
        break;
      end
    end
    checkCount++; if (!seen) $display("[TB] FAIL donecyc_done_seen: got no done, expected done"); else passCount++;
    bus.i_start = 1'b1;
    @(negedge clk);
    checkCount++; if (bus.o_busy !== 1'b0) $display("[TB] FAIL donecyc_start_ignored: got busy %b, expected 0", bus.o_busy); else passCount++;
    checkCount++; if (bus.o_ackError !== 1'b1) $display("[TB] FAIL donecyc_ackerr_held: got %b, expected 1", bus.o_ackError); else passCount++;
    @(negedge clk);
    bus.i_start = 1'b0;
    nackMask = 4'b0000;
    checkCount++; if (bus.o_busy !== 1'b1) $display("[TB] FAIL donecyc_start_accepted: got busy %b, expected 1", bus.o_busy); else passCount++;
    checkCount++; if (bus.o_ackError !== 1'b0) $display("[TB] FAIL donecyc_ackerr_cleared: got %b, expected 0", bus.o_ackError); else passCount++;
    waitDone(seen2);
    repeat (3) @(negedge clk);
    checkCount++; if (!seen2) $display("[TB] FAIL donecyc_second_done: got no done, expected done"); else passCount++;
    checkCount++; if (bus.o_ackError !== 1'b0) $display("[TB] FAIL donecyc_final_ackerr: got %b, expected 0", bus.o_ackError); else passCount++;
  endtask

  initial begin
    bus.i_start  = 1'b0;
    bus.i_dataIn = '0;
    resetN = 1'b1;
    #1;
    test_reset();
    test_reset_mid_frame();
    test_frame();
    test_nack();
    test_back_to_back();
    test_done_cycle();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #500us;
    $display("[TB] FAIL watchdog: simulation still running at 500us, expected completion");
    $fatal(1);
  end
endmodule
